bcd_to_bin_seq: RTL and testbench
=================================

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 Parameter DIGITS, default 3: number of packed BCD input digits.
REQ-002 Parameter BIN_W, default 10: binary result width; SHALL satisfy 2^BIN_W > 10^DIGITS - 1.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 i_clk  input  1: sole clock, rising edge.
REQ-005 i_rst_n  input  1: asynchronous active-low reset.
REQ-006 i_start  input  1: conversion request, sampled only in IDLE.
REQ-007 i_bcd  input  4*DIGITS: packed BCD operand; digit 0 = bits [3:0], most significant digit at the top.
REQ-008 o_busy  output  1: high whenever state is not IDLE.
REQ-009 o_done  output  1: one-cycle pulse marking a valid o_bin/o_error.
REQ-010 o_bin  output  BIN_W: binary result, held until the next o_done.
REQ-011 o_error  output  1: high when the last captured operand had a digit > 9; held until the next o_done.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-013 IDLE with i_start=1: capture i_bcd into the BCD section of a shift register of width 4*DIGITS+BIN_W, clear the binary section, clear the iteration counter, and check every digit.
REQ-014 If any captured digit > 9: go to DONE; o_bin=0 and o_error=1 are loaded at the DONE entry.
REQ-015 If all digits are valid: go to SHIFT; o_error=0 is loaded on completion.
REQ-016 Each SHIFT cycle: shift the whole register right by one bit, with the BCD LSB entering the binary MSB.
REQ-017 After each shift, every BCD digit >= 8 SHALL have 3 subtracted (reverse double-dabble).
REQ-018 SHIFT SHALL last exactly BIN_W cycles, counted by a counter of width clog2(BIN_W+1); after the BIN_W-th cycle go to DONE.
REQ-019 DONE lasts one cycle: o_done=1, o_bin = binary section, then return to IDLE.
REQ-020 Latency: start accepted at edge 0 gives o_done high in cycle BIN_W+1 for a valid operand, and in cycle 1 for an error operand.
REQ-021 i_start while in SHIFT or DONE SHALL be ignored; no queuing.
REQ-022 i_bcd changes after capture SHALL NOT affect the running conversion.
REQ-023 i_start held high continuously SHALL start a new conversion on each return to IDLE.
REQ-024 Operand 0 SHALL yield o_bin=0 after the full BIN_W cycles, with no early exit.

Reset
REQ-025 While i_rst_n=0: state=IDLE, counter=0, shift register=0, o_busy=0, o_done=0, o_bin=0, o_error=0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion immediately; no o_done is produced for the aborted operand.
REQ-027 After reset release, the first i_start SHALL be accepted on the first rising edge with i_rst_n=1.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the state encodings (IDLE, SHIFT, DONE) and the digit-adjust constants (threshold 8, correction 3).
REQ-029 One sub-module bcd_digit_adjust (4-bit in, 4-bit out: subtract 3 if >= 8) SHALL be instantiated DIGITS times via generate.
REQ-030 All state SHALL be in a single clock domain; there SHALL be no combinational path from i_start to o_done.

Verification
REQ-031 i_bcd=12'h999, start pulse -> o_done in cycle 11, o_bin=10'd999, o_error=0, o_busy high in cycles 1-11.
REQ-032 i_bcd=12'h512 -> o_bin=10'h200; i_bcd=12'h000 -> o_bin=0, o_done in cycle 11.
REQ-033 i_bcd=12'h1A5 -> o_done in cycle 1, o_error=1, o_bin=0; a following 12'h007 -> o_error=0, o_bin=7.
REQ-034 i_start pulsed in cycle 5 of a 12'h250 conversion -> single o_done, o_bin=250, no second conversion.
REQ-035 i_rst_n low in cycle 6 of a conversion -> all outputs 0 on assertion, no o_done; a restart with 12'h123 -> o_bin=123.
REQ-036 Exhaustive sweep of all 1000 valid operands against a reference model, with back-to-back starts.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_t         - converter FSM encoding (IDLE, SHIFT, DONE)
//   ADJ_THRESH      - digit value at/above which a correction is applied
//   ADJ_CORR        - correction subtracted from such a digit
//   BCD_MAX_DIGIT   - largest legal BCD digit value
//   digit_invalid() - flags a nibble that is not a legal BCD digit
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Reverse double-dabble: after each right shift a digit that reads >= 8
    // has just received a "5" from the digit above it (an odd upper digit
    // halved), so 3 is removed to turn the binary weight 8 into BCD weight 5.
    localparam logic [3:0] ADJ_THRESH    = 4'd8;
    localparam logic [3:0] ADJ_CORR      = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic digit_invalid(input logic [3:0] dig);
        return (dig > BCD_MAX_DIGIT);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// Single-digit correction for reverse double-dabble: subtract 3 if >= 8.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
//
// Ports:
//   i_dig - 4-bit digit after the register shift
//   o_dig - corrected 4-bit digit
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    always_comb begin
        o_dig = i_dig;
        if (i_dig >= ADJ_THRESH) begin
            o_dig = i_dig - ADJ_CORR;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Latency: BIN_W+1 cycles from accepted start to o_done (1 cycle for a bad digit).
// Backpressure: none; i_start is sampled only in IDLE, ignored otherwise (no queuing).
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_start  - conversion request, sampled in IDLE
//   i_bcd    - packed BCD operand, digit 0 in bits [3:0]
//   o_busy   - high whenever the FSM is not in IDLE
//   o_done   - one-cycle pulse: o_bin/o_error valid
//   o_bin    - binary result, held until the next o_done
//   o_error  - last captured operand had a digit > 9, held until next o_done
//
// Parameters: DIGITS BCD digits in, BIN_W result bits; 2^BIN_W must exceed
// 10^DIGITS - 1 so the BCD section is fully drained after BIN_W shifts.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_bcd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [BIN_W-1:0]      o_bin,
    output logic                  o_error
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q,    sr_d;      // {bcd section, binary section}
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic               err_q,   err_d;

    // ------------------------------------------------------------------
    // Datapath: one shift plus per-digit correction
    // ------------------------------------------------------------------
    logic [SR_W-1:0]    sr_shift;   // register shifted right by one
    logic [BCD_W-1:0]   bcd_adj;    // corrected BCD section after the shift
    logic [SR_W-1:0]    sr_step;    // full register value after one SHIFT cycle
    logic [DIGITS-1:0]  dig_bad;    // per-digit legality of the incoming operand
    logic               any_bad;

    // The BCD LSB falls into the binary MSB naturally with a whole-register
    // logical shift; a zero enters the top of the BCD section.
    assign sr_shift = sr_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_adjust u_adj (
            .i_dig (sr_shift[BIN_W + 4*g +: 4]),
            .o_dig (bcd_adj[4*g +: 4])
        );

        assign dig_bad[g] = digit_invalid(i_bcd[4*g +: 4]);
    end

    assign sr_step = {bcd_adj, sr_shift[BIN_W-1:0]};
    assign any_bad = |dig_bad;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    sr_d  = {i_bcd, {BIN_W{1'b0}}};
                    cnt_d = '0;
                    if (any_bad) begin
                        // Malformed operand: skip the shift phase entirely and
                        // publish a zero result with the error flag.
                        state_d = DONE;
                        bin_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CNT_ONE;
                // Always run the full BIN_W shifts, even for a zero operand,
                // so latency is data independent.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    bin_d   = sr_step[BIN_W-1:0];
                    err_d   = 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers, so i_start never reaches o_done
    // combinationally.
    // ------------------------------------------------------------------
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);
    assign o_bin   = bin_q;
    assign o_error = err_q;

endmodule : bcd_to_bin_seq

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (DIGITS=3, BIN_W=10).
// Latency: n/a (simulation only).
// Backpressure: n/a.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int VALID_LAT = BIN_W + 1;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_start;
    logic [11:0]       i_bcd;
    logic              o_busy;
    logic              o_done;
    logic [BIN_W-1:0]  o_bin;
    logic              o_error;

    int tests;
    int fails;

    bcd_to_bin_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_bcd   (i_bcd),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bin   (o_bin),
        .o_error (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Reference model: decimal value of the digits, error if any digit > 9
    // ------------------------------------------------------------------
    function automatic int ref_val(input logic [11:0] b);
        int v = 0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            v = v * 10 + int'(b[4*d +: 4]);
        end
        return v;
    endfunction

    function automatic bit ref_err(input logic [11:0] b);
        bit e = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (b[4*d +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Drives one start pulse from IDLE (caller sits #1 after an edge) and
    // reports what the DUT produced. lat is the cycle of o_done after the
    // accepting edge, 0 if it never came. i_bcd is scrambled after capture.
    task automatic do_conv(input logic [11:0] bcd, output int lat,
                           output logic [BIN_W-1:0] bin, output logic err,
                           output bit busy_ok);
        busy_ok = 1'b1;
        lat     = 0;
        i_bcd   = bcd;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_bcd   = 12'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (o_done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge i_clk); #1;
        end
        bin = o_bin;
        err = o_error;
        @(posedge i_clk); #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #1;
        tests++;
        if ({o_busy, o_done, o_error} !== 3'b000 || o_bin !== '0) begin
            fails++;
            $display("FAIL reset_async: busy=%b done=%b err=%b bin=%0d, required all 0",
                     o_busy, o_done, o_error, o_bin);
        end
        i_start = 1'b1;
        i_bcd   = 12'h999;
        repeat (3) @(posedge i_clk);
        #1;
        tests++;
        if ({o_busy, o_done, o_error} !== 3'b000 || o_bin !== '0) begin
            fails++;
            $display("FAIL reset_held: busy=%b done=%b err=%b bin=%0d, required all 0 with start high",
                     o_busy, o_done, o_error, o_bin);
        end
        i_start = 1'b0;
        i_rst_n = 1'b1;
    endtask

    task automatic test_known_vectors();
        logic [11:0]      vec [3];
        int               lat;
        logic [BIN_W-1:0] bin;
        logic             err;
        bit               busy_ok;
        vec[0] = 12'h999;
        vec[1] = 12'h512;
        vec[2] = 12'h000;
        for (int i = 0; i < 3; i++) begin
            do_conv(vec[i], lat, bin, err, busy_ok);
            tests++;
            if (lat != VALID_LAT) begin
                fails++;
                $display("FAIL vec_latency %h: done in cycle %0d, required %0d", vec[i], lat, VALID_LAT);
            end
            tests++;
            if (bin !== BIN_W'(ref_val(vec[i])) || err !== 1'b0) begin
                fails++;
                $display("FAIL vec_result %h: bin=%0d err=%b, required bin=%0d err=0",
                         vec[i], bin, err, ref_val(vec[i]));
            end
            tests++;
            if (!busy_ok) begin
                fails++;
                $display("FAIL vec_busy %h: busy dropped before done, required high cycles 1-%0d",
                         vec[i], VALID_LAT);
            end
            tests++;
            if (o_busy !== 1'b0) begin
                fails++;
                $display("FAIL vec_idle %h: busy=%b after done, required 0", vec[i], o_busy);
            end
        end
    endtask

    task automatic test_error();
        int               lat;
        logic [BIN_W-1:0] bin;
        logic             err;
        bit               busy_ok;
        logic [11:0]      b;
        int               exp_lat;
        logic [BIN_W-1:0] exp_bin;

        do_conv(12'h1A5, lat, bin, err, busy_ok);
        tests++;
        if (lat != 1 || err !== 1'b1 || bin !== '0) begin
            fails++;
            $display("FAIL err_1A5: lat=%0d err=%b bin=%0d, required lat=1 err=1 bin=0", lat, err, bin);
        end
        do_conv(12'h007, lat, bin, err, busy_ok);
        tests++;
        if (lat != VALID_LAT || err !== 1'b0 || bin !== BIN_W'(7)) begin
            fails++;
            $display("FAIL err_clear_007: lat=%0d err=%b bin=%0d, required lat=%0d err=0 bin=7",
                     lat, err, bin, VALID_LAT);
        end
        for (int i = 0; i < 24; i++) begin
            b       = 12'($urandom);
            exp_lat = ref_err(b) ? 1 : VALID_LAT;
            exp_bin = ref_err(b) ? '0 : BIN_W'(ref_val(b));
            do_conv(b, lat, bin, err, busy_ok);
            tests++;
            if (lat != exp_lat || err !== ref_err(b) || bin !== exp_bin) begin
                fails++;
                $display("FAIL err_random %h: lat=%0d err=%b bin=%0d, required lat=%0d err=%b bin=%0d",
                         b, lat, err, bin, exp_lat, ref_err(b), exp_bin);
            end
        end
    endtask

    task automatic test_start_ignored();
        int               ndone = 0;
        int               first = 0;
        logic [BIN_W-1:0] bin_at = '0;
        i_bcd   = 12'h250;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (o_done === 1'b1) begin
                ndone++;
                if (first == 0) begin
                    first  = c;
                    bin_at = o_bin;
                end
            end
            if (c == 5) begin
                i_start = 1'b1;
                i_bcd   = 12'h999;
            end else if (c == 6) begin
                i_start = 1'b0;
            end
            @(posedge i_clk); #1;
        end
        tests++;
        if (ndone != 1 || first != VALID_LAT) begin
            fails++;
            $display("FAIL ignore_start: %0d done pulses first at cycle %0d, required 1 at cycle %0d",
                     ndone, first, VALID_LAT);
        end
        tests++;
        if (bin_at !== BIN_W'(250) || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_result: bin=%0d busy=%b, required bin=250 busy=0", bin_at, o_busy);
        end
    endtask

    task automatic test_reset_abort();
        bit               saw_done = 1'b0;
        int               lat;
        logic [BIN_W-1:0] bin;
        logic             err;
        bit               busy_ok;
        i_bcd   = 12'h777;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            if (o_done === 1'b1) saw_done = 1'b1;
            @(posedge i_clk); #1;
        end
        i_rst_n = 1'b0;
        #1;
        tests++;
        if ({o_busy, o_done, o_error} !== 3'b000 || o_bin !== '0) begin
            fails++;
            $display("FAIL abort_outputs: busy=%b done=%b err=%b bin=%0d, required all 0",
                     o_busy, o_done, o_error, o_bin);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            if (o_done === 1'b1) saw_done = 1'b1;
        end
        i_rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (o_done === 1'b1) saw_done = 1'b1;
            @(posedge i_clk); #1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL abort_no_done: done seen=1, required 0 for aborted operand");
        end
        do_conv(12'h123, lat, bin, err, busy_ok);
        tests++;
        if (lat != VALID_LAT || bin !== BIN_W'(123) || err !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: lat=%0d bin=%0d err=%b, required lat=%0d bin=123 err=0",
                     lat, bin, err, VALID_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ops [1000];
        logic [11:0] tmp;
        int          j;
        int          k = 0;
        int          c = 0;
        int          prev_c = 0;
        for (int v = 0; v < 1000; v++) ops[v] = to_bcd(v);
        for (int i = 999; i > 0; i--) begin
            j      = int'($urandom_range(i, 0));
            tmp    = ops[i];
            ops[i] = ops[j];
            ops[j] = tmp;
        end
        i_bcd   = ops[0];
        i_start = 1'b1;
        while (k < 1000 && c < 1000 * 20) begin
            @(posedge i_clk); #1;
            c++;
            if (o_done === 1'b1) begin
                tests++;
                if (o_bin !== BIN_W'(ref_val(ops[k])) || o_error !== 1'b0) begin
                    fails++;
                    $display("FAIL sweep %h: bin=%0d err=%b, required bin=%0d err=0",
                             ops[k], o_bin, o_error, ref_val(ops[k]));
                end
                if (k > 0) begin
                    tests++;
                    if (c - prev_c != BIN_W + 2) begin
                        fails++;
                        $display("FAIL sweep_period %h: %0d cycles between done, required %0d",
                                 ops[k], c - prev_c, BIN_W + 2);
                    end
                end
                prev_c = c;
                k++;
                if (k < 1000) i_bcd = ops[k];
            end
        end
        i_start = 1'b0;
        tests++;
        if (k != 1000) begin
            fails++;
            $display("FAIL sweep_timeout: %0d conversions completed, required 1000", k);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        tests   = 0;
        fails   = 0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_bcd   = '0;

        test_reset();
        test_known_vectors();
        test_error();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bcd_to_bin_seq
